// File: rtl/add_serial_feeder.sv
// add_serial_feeder: operand sequencer for the 8-bit serial adder.
// Buffers (a,b) pairs in a small FIFO, launches one add at a time with the
// operands held stable, waits a fixed latency, then offers the sum together
// with its operands on a result stream.
//
// Handshake rule for both streams: a transfer happens on a rising clk edge
// where valid && ready are both high; a source holding valid keeps its data
// stable until that edge, and valid never depends combinationally on ready.
module add_serial_feeder #(
    parameter int W         = 8,
    parameter int DEPTH     = 4,
    parameter int EN_CYCLES = 2,
    parameter int LATENCY   = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_a,
    input  logic [W-1:0]             in_b,
    output logic [W-1:0]             add_a,
    output logic [W-1:0]             add_b,
    output logic                     add_en,
    input  logic [W-1:0]             add_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [W-1:0]             res_sum,
    output logic [W-1:0]             res_a,
    output logic [W-1:0]             res_b,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int AW      = $clog2(DEPTH);
    localparam int CNT_MAX = (EN_CYCLES > LATENCY) ? EN_CYCLES : LATENCY;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
    localparam logic [CW-1:0] EN_LAST    = CW'(EN_CYCLES - 1);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;

    logic [W-1:0]  mem_a [DEPTH];
    logic [W-1:0]  mem_b [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic push;
    logic pop;

    // Full is judged from registered occupancy only; a full FIFO refuses even
    // in a cycle where it is also popping.
    assign in_ready = (fifo_count != COUNT_FULL);
    assign push     = in_valid && in_ready;
    assign pop      = (state == S_IDLE) && (fifo_count != '0) && !res_valid;

    // add_en is decoded from state so reset drops it without waiting for a clock.
    assign add_en = (state == S_LAUNCH);
    assign busy   = (state != S_IDLE);

    // FIFO storage; contents are meaningless while empty, so no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + COUNT_ONE;
                2'b01:   fifo_count <= fifo_count - COUNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Launch/wait/hold sequencer; add_a/add_b change only on a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            add_a     <= '0;
            add_b     <= '0;
            op_a      <= '0;
            op_b      <= '0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_a     <= '0;
            res_b     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        add_a <= mem_a[rd_ptr];
                        add_b <= mem_b[rd_ptr];
                        op_a  <= mem_a[rd_ptr];
                        op_b  <= mem_b[rd_ptr];
                        cnt   <= '0;
                        state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (cnt == EN_LAST) begin
                        cnt   <= '0;
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        cnt       <= '0;
                        res_sum   <= add_out;
                        res_a     <= op_a;
                        res_b     <= op_b;
                        res_valid <= 1'b1;
                        state     <= S_HOLD;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/add_serial_feeder.md
Name: add_serial_feeder

Overview:
- Operand sequencer placed around the 8-bit serial adder.
- Accepts (a,b) operand pairs on a valid/ready input stream and buffers them in a small FIFO.
- Drives the adder's a/b/en inputs one pair at a time and holds the operands stable for the whole add.
- After a fixed latency, captures the adder's out bus and presents the sum with its operands on a valid/ready result stream.

Parameters:
- W, 8: operand and result width; must match the adder.
- DEPTH, 4: operand FIFO entries; power of two, ≥2.
- EN_CYCLES, 2: consecutive cycles add_en is held high per launch. 2 covers an adder parked in DONE (first cycle returns it to IDLE, second loads).
- LATENCY, 9: WAIT-state cycles after the last en cycle before add_out is sampled; ≥1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  FIFO can accept
- in_a  in  W  operand a
- in_b  in  W  operand b
- add_a  out  W  to adder a
- add_b  out  W  to adder b
- add_en  out  1  to adder en
- add_out  in  W  from adder out
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts result
- res_sum  out  W  captured sum
- res_a  out  W  operand a of this result
- res_b  out  W  operand b of this result
- busy  out  1  FSM not in S_IDLE
- fifo_count  out  clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, immediate): FIFO empty, fifo_count=0, in_ready=1, add_en=0, add_a=add_b=0, res_valid=0, res_sum=res_a=res_b=0, FSM=S_IDLE, internal counters=0.
- FIFO:
  - Push when in_valid&&in_ready. in_ready = (fifo_count!=DEPTH), registered-state based, with no same-cycle pop look-ahead; a full FIFO refuses even when popping.
  - Pop happens only on the S_IDLE→S_LAUNCH transition.
  - Simultaneous push+pop leaves fifo_count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM:
  - S_IDLE: if FIFO non-empty and res_valid==0 → pop head into add_a/add_b and the op_a/op_b shadow registers, clear cnt, go S_LAUNCH. Otherwise stay. add_en=0.
  - S_LAUNCH: add_en=1 for exactly EN_CYCLES cycles (cnt 0..EN_CYCLES-1), then clear cnt and go S_WAIT.
  - S_WAIT: add_en=0, cnt increments. At the edge ending the LATENCY-th WAIT cycle:
    - res_sum<=add_out, res_a<=op_a, res_b<=op_b, res_valid<=1;
    - go S_HOLD.
  - S_HOLD: res_valid=1; res_sum/res_a/res_b stable. On res_valid&&res_ready, clear res_valid next edge and go S_IDLE.
- add_a/add_b hold the launched operands from S_LAUNCH entry until the next pop; they are never changed during S_LAUNCH/S_WAIT. The adder samples a/b in its FSM transitions, so operands must stay stable.
- Throughput: one result per EN_CYCLES+LATENCY+2 cycles minimum (IDLE + LAUNCH + WAIT + HOLD handshake).
- Back-to-back: with res_ready tied high, the next launch starts the cycle after S_HOLD exits.
- Input stream keeps filling the FIFO while the FSM is busy or a result is stalled.
- Result stall: res_valid stays high and outputs stay frozen indefinitely until res_ready. No new launch occurs while res_valid=1.
- Arithmetic: sum is whatever the adder produces (W bits, carry-out discarded). The feeder does no arithmetic and no checking.
- Reset mid-operation: any state → S_IDLE immediately. In-flight pair and FIFO contents are lost. add_en drops asynchronously.
- in_valid with in_ready=0: no push; the source must hold its data.

Test Plan:
- Single op: after reset, push (a=8'h03,b=8'h05) with res_ready=1 and a behavioural adder model. Required: add_en high exactly 2 cycles; res_valid rises 1 edge after the 9th WAIT cycle; res_sum=8'h08, res_a=03, res_b=05; pulse lasts 1 cycle.
- Overflow/wrap: push (8'hFF,8'h01). Required: res_sum=8'h00 (carry dropped). Then push (8'h80,8'h80). Required: res_sum=8'h00.
- FIFO full: hold res_ready=0, push 6 pairs back-to-back. Required:
  - 1 pair launched and stalled in S_HOLD;
  - fifo_count reaches 4 and in_ready=0;
  - the 6th pair is not accepted until res_ready=1;
  - results emerge in push order.
- Simultaneous push+pop: FIFO holds 1 entry, FSM in S_IDLE, in_valid=1. Required: fifo_count stays 1 across the edge; the popped pair appears on add_a/add_b.
- Operand stability: during S_LAUNCH/S_WAIT, push new pairs every cycle. Required: add_a/add_b unchanged until the next S_IDLE pop.
- Reset mid-op: assert rst during the 4th WAIT cycle. Required, same cycle: add_en=0, res_valid=0, fifo_count=0, busy=0. The next pushed pair (8'h10,8'h22) completes with res_sum=8'h32.
